// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: measurement sequencer for a ring-oscillator PUF array.
// A challenge picks two oscillators (A and B). The controller enables the
// array, waits a settle interval, and counts synchronized rising edges of
// both oscillators over a fixed window. It then reports A > B as the
// response bit, along with the raw counts.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous, active-low reset
//   start_i      measurement request, sampled only in IDLE
//   challenge_i  {index A, index B}
//   ro_i         raw oscillator outputs (asynchronous to clk_i)
//   ro_en_o      oscillator array enable
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse when a result or error is ready
//   response_o   count A > count B
//   tie_o        count A == count B
//   err_o        challenge rejected
//   count_a_o    final edge count of oscillator A
//   count_b_o    final edge count of oscillator B
module ro_puf_ctrl #(
  parameter int NUM_RO = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [2*SEL_W-1:0] challenge_i,
  input  logic [NUM_RO-1:0]  ro_i,
  output logic               ro_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               response_o,
  output logic               tie_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   count_a_o,
  output logic [CNT_W-1:0]   count_b_o
);

  // One timer serves both the settle and the window phases.
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [SEL_W:0]   NUM_RO_L    = (SEL_W+1)'(NUM_RO);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_COUNT   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e             state_q;
  logic [2*SEL_W-1:0] chal_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   cnt_a_q, cnt_b_q;
  logic [2:0]         sync_a_q, sync_b_q;
  logic               ro_en_q, busy_q, done_q, response_q, tie_q, err_q;
  logic [CNT_W-1:0]   count_a_q, count_b_q;

  logic [SEL_W-1:0]   idx_a_s, idx_b_s;
  logic               sel_a_s, sel_b_s;
  logic               edge_a_s, edge_b_s;

  // A challenge is usable only if both indices exist and differ.
  function automatic logic chal_valid(input logic [2*SEL_W-1:0] c);
    logic [SEL_W:0] a;
    logic [SEL_W:0] b;
    a = {1'b0, c[2*SEL_W-1:SEL_W]};
    b = {1'b0, c[SEL_W-1:0]};
    return (a != b) && (a < NUM_RO_L) && (b < NUM_RO_L);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign idx_a_s = chal_q[2*SEL_W-1:SEL_W];
  assign idx_b_s = chal_q[SEL_W-1:0];

  // Select oscillators A and B from the array using the latched challenge.
  always_comb begin
    sel_a_s = 1'b0;
    sel_b_s = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      sel_a_s = sel_a_s | (ro_i[i] & (idx_a_s == SEL_W'(i)));
      sel_b_s = sel_b_s | (ro_i[i] & (idx_b_s == SEL_W'(i)));
    end
  end

  // Two-flop synchronizer plus delay flop per selected oscillator; runs every cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync_a_q <= 3'b000;
      sync_b_q <= 3'b000;
    end else begin
      sync_a_q <= {sync_a_q[1:0], sel_a_s};
      sync_b_q <= {sync_b_q[1:0], sel_b_s};
    end
  end

  // Bit 1 is the synchronized value, bit 2 its one-cycle-old copy.
  assign edge_a_s = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b_s = sync_b_q[1] & ~sync_b_q[2];

  // Measurement sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      chal_q     <= {(2*SEL_W){1'b0}};
      tmr_q      <= {TMR_W{1'b0}};
      cnt_a_q    <= {CNT_W{1'b0}};
      cnt_b_q    <= {CNT_W{1'b0}};
      ro_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      err_q      <= 1'b0;
      count_a_q  <= {CNT_W{1'b0}};
      count_b_q  <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            // Results from the previous run are dropped at acceptance.
            chal_q     <= challenge_i;
            busy_q     <= 1'b1;
            tmr_q      <= {TMR_W{1'b0}};
            cnt_a_q    <= {CNT_W{1'b0}};
            cnt_b_q    <= {CNT_W{1'b0}};
            response_q <= 1'b0;
            tie_q      <= 1'b0;
            count_a_q  <= {CNT_W{1'b0}};
            count_b_q  <= {CNT_W{1'b0}};
            if (chal_valid(challenge_i)) begin
              state_q <= ST_SETTLE;
              ro_en_q <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            tmr_q   <= {TMR_W{1'b0}};
            state_q <= ST_COUNT;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_COUNT: begin
          cnt_a_q <= sat_inc(cnt_a_q, edge_a_s);
          cnt_b_q <= sat_inc(cnt_b_q, edge_b_s);
          if (tmr_q == WINDOW_LAST) begin
            tmr_q   <= {TMR_W{1'b0}};
            ro_en_q <= 1'b0;
            state_q <= ST_COMPARE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_COMPARE: begin
          // Equal counts (including both saturated) always give response 0.
          response_q <= (cnt_a_q > cnt_b_q);
          tie_q      <= (cnt_a_q == cnt_b_q);
          count_a_q  <= cnt_a_q;
          count_b_q  <= cnt_b_q;
          err_q      <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ro_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ro_en_o    = ro_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign response_o = response_q;
  assign tie_o      = tie_q;
  assign err_o      = err_q;
  assign count_a_o  = count_a_q;
  assign count_b_o  = count_b_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Testbench for ro_puf_ctrl: table vectors, randomized oscillator patterns
// against a sampled-waveform reference model, and hand-written corner cases
// (invalid challenges, saturation, mid-run reset, start while busy).
module tb_ro_puf_ctrl;

  localparam int W     = 64;
  localparam int S     = 4;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_m = 1'b0, start_12 = 1'b0, start_s = 1'b0;
  logic [7:0]  chal = 8'h00;
  logic [15:0] ro = 16'h0000;

  logic        m_en, m_busy, m_done, m_resp, m_tie, m_err;
  logic [15:0] m_ca, m_cb;
  logic        x_en, x_busy, x_done, x_resp, x_tie, x_err;
  logic [15:0] x_ca, x_cb;
  logic        s_en, s_busy, s_done, s_resp, s_tie, s_err;
  logic [3:0]  s_ca, s_cb;

  int checks = 0;
  int errors = 0;

  int edge_no = 0;
  logic [15:0] samp_log [DEPTH];
  int ro_per [16];
  int ro_ph  [16];

  ro_puf_ctrl #(.NUM_RO(16), .SEL_W(4), .CNT_W(16), .WINDOW(W), .SETTLE(S)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_m), .challenge_i(chal), .ro_i(ro),
    .ro_en_o(m_en), .busy_o(m_busy), .done_o(m_done), .response_o(m_resp),
    .tie_o(m_tie), .err_o(m_err), .count_a_o(m_ca), .count_b_o(m_cb));

  ro_puf_ctrl #(.NUM_RO(12), .SEL_W(4), .CNT_W(16), .WINDOW(W), .SETTLE(S)) u_dut12 (
    .clk_i(clk), .rst_i(rst), .start_i(start_12), .challenge_i(chal), .ro_i(ro[11:0]),
    .ro_en_o(x_en), .busy_o(x_busy), .done_o(x_done), .response_o(x_resp),
    .tie_o(x_tie), .err_o(x_err), .count_a_o(x_ca), .count_b_o(x_cb));

  ro_puf_ctrl #(.NUM_RO(16), .SEL_W(4), .CNT_W(4), .WINDOW(W), .SETTLE(S)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start_s), .challenge_i(chal), .ro_i(ro),
    .ro_en_o(s_en), .busy_o(s_busy), .done_o(s_done), .response_o(s_resp),
    .tie_o(s_tie), .err_o(s_err), .count_a_o(s_ca), .count_b_o(s_cb));

  always #5 clk = ~clk;

  // Record what every DUT sees on ro_i at each rising edge, labelled by edge number.
  always @(posedge clk) begin
    samp_log[edge_no % DEPTH] <= ro;
    edge_no <= edge_no + 1;
  end

  // Square-wave oscillators; edge_no here is the label of the coming rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (ro_per[i] == 0) ro[i] = 1'b0;
      else ro[i] = (((edge_no + ro_ph[i]) % ro_per[i]) < (ro_per[i] / 2));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [31:0] act, input int lo, input int hi);
    checks++;
    if ($isunknown(act) || (int'(act) < lo) || (int'(act) > hi)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Reference: a rising transition of oscillator b between two consecutive
  // samples is seen by the counter two edges later (synchronizer depth).
  // The counter is open for the W edges after the settle phase, so the
  // transitions it sees are those whose high sample lies in
  // [k+S-1, k+S+W-2] for a start accepted at edge k. Result saturates at cmax.
  function automatic int model_cnt(input int k, input int b, input int cmax);
    int c = 0;
    for (int j = k + S - 1; j <= k + S + W - 2; j++) begin
      if (samp_log[j % DEPTH][b] && !samp_log[(j - 1) % DEPTH][b]) c++;
    end
    return (c > cmax) ? cmax : c;
  endfunction

  task automatic set_plan_pattern();
    for (int i = 0; i < 16; i++) begin ro_per[i] = 0; ro_ph[i] = 0; end
    ro_per[3] = 8;
    ro_per[7] = 16;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one request to the main DUT and follow it to done_o (bounded).
  // With disturb set, a second start with a different challenge is pulsed
  // mid-run and the challenge input is left changed.
  task automatic measure(input logic [7:0] c, input bit disturb,
                         output int k, output int lat, output int en_cyc, output bit tmo);
    @(negedge clk);
    chal = c;
    start_m = 1'b1;
    k = edge_no;
    @(negedge clk);
    start_m = 1'b0;
    lat = 0; en_cyc = 0; tmo = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      if (disturb && n == 10) begin start_m = 1'b1; chal = 8'h73; end
      if (disturb && n == 11) start_m = 1'b0;
      if (m_en) en_cyc++;
      if (m_done) begin lat = n; tmo = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  // Compare main DUT results against the reference for challenge c.
  task automatic check_main(input string tag, input logic [7:0] c, input int k,
                            input int lat, input int en_cyc, input bit tmo);
    int a, b, ea, eb;
    bit bad;
    a = int'(c[7:4]);
    b = int'(c[3:0]);
    bad = (a == b) || (a >= 16) || (b >= 16);
    chk({tag, "_timeout"}, tmo, 0);
    if (bad) begin
      ea = 0; eb = 0;
      chk({tag, "_lat"}, lat, 1);
      chk({tag, "_en_cycles"}, en_cyc, 0);
    end else begin
      ea = model_cnt(k, a, 65535);
      eb = model_cnt(k, b, 65535);
      chk({tag, "_lat"}, lat, S + W + 2);
      chk({tag, "_en_cycles"}, en_cyc, S + W);
    end
    chk({tag, "_err"}, m_err, bad);
    chk({tag, "_count_a"}, m_ca, ea);
    chk({tag, "_count_b"}, m_cb, eb);
    chk({tag, "_resp"}, m_resp, (ea > eb));
    chk({tag, "_tie"}, m_tie, (!bad && ea == eb));
    @(negedge clk);
    chk({tag, "_done_width"}, m_done, 0);
    chk({tag, "_busy_after"}, m_busy, 0);
    chk({tag, "_hold_a"}, m_ca, ea);
  endtask

  typedef struct {
    logic [7:0] chal;
    int         mode;   // 0: plan waveform, 1: all oscillators quiet
    bit         err;
    bit         resp;
    bit         tie;
    int         a_lo, a_hi, b_lo, b_hi;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int k, lat, en_cyc, dones, exp_s;
    bit tmo;

    tbl[0] = '{8'h37, 0, 1'b0, 1'b1, 1'b0, 7, 8, 3, 4};
    tbl[1] = '{8'h73, 0, 1'b0, 1'b0, 1'b0, 3, 4, 7, 8};
    tbl[2] = '{8'h55, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
    tbl[3] = '{8'h12, 1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin ro_per[i] = 0; ro_ph[i] = 0; end

    // Reset state
    rst = 1'b0;
    idle(3);
    chk("reset_en", m_en, 0);
    chk("reset_busy", m_busy, 0);
    chk("reset_done", m_done, 0);
    chk("reset_err", m_err, 0);
    chk("reset_counts", {m_ca, m_cb}, 0);
    rst = 1'b1;
    idle(2);

    // Table vectors
    for (int t = 0; t < 4; t++) begin
      if (tbl[t].mode == 0) set_plan_pattern();
      else for (int i = 0; i < 16; i++) ro_per[i] = 0;
      idle(8);
      measure(tbl[t].chal, 1'b0, k, lat, en_cyc, tmo);
      chk($sformatf("tbl%0d_err", t), m_err, tbl[t].err);
      chk($sformatf("tbl%0d_resp", t), m_resp, tbl[t].resp);
      chk($sformatf("tbl%0d_tie", t), m_tie, tbl[t].tie);
      chk_rng($sformatf("tbl%0d_count_a", t), m_ca, tbl[t].a_lo, tbl[t].a_hi);
      chk_rng($sformatf("tbl%0d_count_b", t), m_cb, tbl[t].b_lo, tbl[t].b_hi);
      check_main($sformatf("tbl%0d", t), tbl[t].chal, k, lat, en_cyc, tmo);
    end

    // Second start and challenge change while busy have no effect
    set_plan_pattern();
    idle(4);
    measure(8'h37, 1'b1, k, lat, en_cyc, tmo);
    chk("busy_start_resp", m_resp, 1);
    check_main("busy_start", 8'h37, k, lat, en_cyc, tmo);

    // Randomized oscillator patterns and challenges
    for (int r = 0; r < 12; r++) begin
      logic [7:0] c;
      for (int i = 0; i < 16; i++) begin
        ro_per[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(3, 24));
        ro_ph[i]  = int'($urandom_range(0, 23));
      end
      c = 8'($urandom_range(0, 255));
      if (r == 5) c[3:0] = c[7:4];
      idle(int'($urandom_range(1, 6)));
      measure(c, 1'b0, k, lat, en_cyc, tmo);
      check_main($sformatf("rnd%0d", r), c, k, lat, en_cyc, tmo);
    end

    // Index beyond a 12-oscillator array is rejected
    @(negedge clk);
    chal = 8'hC1;
    start_12 = 1'b1;
    @(negedge clk);
    start_12 = 1'b0;
    chk("n12_done", x_done, 1);
    chk("n12_err", x_err, 1);
    chk("n12_en", x_en, 0);
    chk("n12_counts", {x_ca, x_cb}, 0);
    @(negedge clk);
    chk("n12_done_width", x_done, 0);
    chk("n12_en_after", x_en, 0);

    // Saturation with 4-bit counters: 16 edges in the window stick at 15
    for (int i = 0; i < 16; i++) begin ro_per[i] = 0; ro_ph[i] = 0; end
    ro_per[1] = 4;
    ro_per[2] = 4;
    idle(4);
    @(negedge clk);
    chal = 8'h12;
    start_s = 1'b1;
    k = edge_no;
    @(negedge clk);
    start_s = 1'b0;
    tmo = 1'b1;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      if (s_done) begin lat = n; tmo = 1'b0; break; end
      @(negedge clk);
    end
    exp_s = model_cnt(k, 1, 15);
    chk("sat_timeout", tmo, 0);
    chk("sat_lat", lat, S + W + 2);
    chk("sat_count_a", s_ca, 15);
    chk("sat_count_b", s_cb, 15);
    chk("sat_model_a", s_ca, exp_s);
    chk("sat_tie", s_tie, 1);
    chk("sat_resp", s_resp, 0);

    // Reset during COUNT aborts the run with no done pulse
    set_plan_pattern();
    idle(4);
    @(negedge clk);
    chal = 8'h37;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    idle(30);
    chk("rst_mid_en_before", m_en, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_en", m_en, 0);
    chk("rst_mid_busy", m_busy, 0);
    chk("rst_mid_done", m_done, 0);
    chk("rst_mid_flags", {m_resp, m_tie, m_err}, 0);
    chk("rst_mid_counts", {m_ca, m_cb}, 0);
    dones = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_done || m_busy) dones++;
    end
    chk("rst_mid_no_done", dones, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_puf_ctrl.md
Name: ro_puf_ctrl

Overview:
Sequencer for the 16-instance ring-oscillator PUF array. It takes a challenge that selects two oscillators, enables the array, and waits for a settle interval. It then counts rising edges of both selected oscillators over a fixed window of clock cycles and outputs a 1-bit response with the raw counts. It sits between the oscillator array (drives its enable, samples its outputs) and the host/key-generation logic that issues challenges.

Parameters:
NUM_RO, 16, number of oscillator inputs
SEL_W, 4, width of each oscillator index in the challenge
CNT_W, 16, edge-counter width
WINDOW, 1024, measurement window length in clk_i cycles (>=1)
SETTLE, 8, cycles between enabling the array and starting the count (>=1)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-low reset
start_i  input  1  request a measurement; sampled only in IDLE
challenge_i  input  2*SEL_W  [2*SEL_W-1:SEL_W]=index A, [SEL_W-1:0]=index B
ro_i  input  NUM_RO  raw oscillator outputs (asynchronous to clk_i)
ro_en_o  output  1  enable to the oscillator array (1 = oscillate)
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse when a result or error is ready
response_o  output  1  1 if count A > count B, else 0
tie_o  output  1  count A == count B
err_o  output  1  challenge rejected
count_a_o  output  CNT_W  final edge count of oscillator A
count_b_o  output  CNT_W  final edge count of oscillator B

Behaviour:
- Reset (rst_i low at a clk_i edge): state IDLE. All outputs 0, counters 0, synchronizers 0. Takes priority over everything. Reset mid-measurement aborts it; no done_o pulse follows.
- States: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE:
  - If start_i=1, latch challenge_i.
  - Invalid challenge (A==B, or A>=NUM_RO, or B>=NUM_RO): go to DONE with err_o=1, ro_en_o stays 0.
  - Valid challenge: go to SETTLE, clear both counters.
- SETTLE: ro_en_o=1. Runs exactly SETTLE cycles, then COUNT.
- COUNT: ro_en_o=1. Runs exactly WINDOW cycles, then COMPARE.
- COMPARE: one cycle. ro_en_o=0. Register the following, then go to DONE:
  - response_o = (cntA > cntB)
  - tie_o = (cntA == cntB)
  - count_a_o / count_b_o = counters
  - err_o = 0
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Result outputs are held from DONE until the next accepted start. At acceptance they are cleared to 0.
- Timing: start accepted at edge k gives:
  - SETTLE on cycles k+1..k+SETTLE
  - COUNT on cycles k+SETTLE+1..k+SETTLE+WINDOW
  - COMPARE on cycle k+SETTLE+WINDOW+1
  - done_o on cycle k+SETTLE+WINDOW+2
- Invalid challenge: done_o on cycle k+1.
- start_i is ignored while busy_o=1; the challenge cannot change mid-measurement.
- Edge detection:
  - Each selected ro_i bit passes through a 2-flop synchronizer plus a delay flop.
  - Edge = sync2 & ~sync3.
  - Synchronizers run every cycle. Edges are counted only in COUNT.
  - Measurable oscillator frequency must be < clk_i/2 (documented limit; not checked).
- Counters saturate at 2^CNT_W-1 (no wrap). A saturated tie reports tie_o=1, response_o=0.
- Tie convention: response_o=0 whenever counts are equal.
- A muxed by index A, B by index B; ro_i bits not selected are ignored.

Test Plan:
- Bench params WINDOW=64, SETTLE=4, CNT_W=16; ro_i[3] square wave period 8 clk, ro_i[7] period 16 clk; challenge=0x37, start pulse -> done_o exactly 70 cycles after the accepting edge; count_a_o in {7,8}, count_b_o in {3,4}, response_o=1, tie_o=0, err_o=0; ro_en_o high for exactly 68 cycles.
- Same stimulus, challenge=0x73 -> response_o=0, counts swapped, tie_o=0.
- Challenge=0x55, and with NUM_RO=12 challenge=0xC1 -> done_o one cycle after start, err_o=1, ro_en_o never asserted, counts 0.
- ro_i held constant 0 on both selected bits, challenge=0x12 -> count_a_o=count_b_o=0, tie_o=1, response_o=0.
- CNT_W=4, WINDOW=64, both selected oscillators period 4 clk -> counts saturate at 15, tie_o=1, no wrap to small values.
- rst_i low for one cycle mid-COUNT -> next cycle all outputs 0, busy_o=0, no done_o pulse. Second start_i pulse while busy -> ignored; challenge change mid-run does not alter counts.
